// File: rtl/gbuff_ps_port.sv
// gbuff_ps_port: PS-side transfer engine for the 32-bit A port of a global
// buffer SRAM. It takes one command at a time, either a burst write or a
// burst read of cmd_len_i consecutive sub-words starting at cmd_addr_i.
//   clk_i, rst_i            clock (shared with buffer clk_a_i), sync active-high reset
//   cmd_*                   command request/accept (valid/ready), direction, address, length
//   s_valid_i/s_ready_o/s_data_i   write-data stream
//   m_valid_o/m_ready_i/m_data_o   read-data stream (full backpressure)
//   busy_o, done_o          engine busy, one-cycle completion pulse
//   en_a_o, we_a_o, addr_a_o, wdata_a_o, rdata_a_i   buffer A port
module gbuff_ps_port #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          en_a_o,
  output logic          we_a_o,
  output logic [AW-1:0] addr_a_o,
  output logic [DW-1:0] wdata_a_o,
  input  logic [DW-1:0] rdata_a_i
);

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] remain;
  logic          inflight;     // read issued last cycle; its data is on rdata_a_i now
  logic [DW-1:0] fifo_mem [2];
  logic          fifo_wp, fifo_rp;
  logic [1:0]    fifo_count;

  logic accept, wr_hs, rd_issue, pop, push, fifo_room;

  // The direction is carried by the WR/RD state itself, so no separate
  // direction register is kept.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    wr_hs       = 1'b0;
    rd_issue    = 1'b0;
    pop         = 1'b0;
    s_ready_o   = 1'b0;
    en_a_o      = 1'b0;
    we_a_o      = 1'b0;
    addr_a_o    = '0;
    wdata_a_o   = '0;
    cmd_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
    done_o      = (state == FIN);
    m_valid_o   = (fifo_count != 2'd0);
    m_data_o    = fifo_mem[fifo_rp];
    push        = inflight;
    fifo_room   = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;

    unique case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (cmd_len_i == '0)  state_n = FIN;
          else if (cmd_write_i) state_n = WR;
          else                  state_n = RD;
        end
      end
      WR: begin
        // Gated by rst_i so a reset cycle never performs a partial write.
        s_ready_o = (remain != '0) && !rst_i;
        wr_hs     = s_valid_i && s_ready_o;
        en_a_o    = wr_hs;
        we_a_o    = wr_hs;
        addr_a_o  = cur_addr;
        wdata_a_o = s_data_i;
        if (wr_hs && remain == LW'(1)) state_n = FIN;
      end
      RD: begin
        pop      = m_valid_o && m_ready_i;
        // A pop frees a slot this cycle, so an issue is safe even when
        // FIFO plus in-flight read already account for both entries.
        rd_issue = (remain != '0) && (fifo_room || pop) && !rst_i;
        en_a_o   = rd_issue;
        addr_a_o = cur_addr;
        if (remain == '0 && !inflight &&
            (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
          state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remain      <= '0;
      inflight    <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_count  <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state    <= state_n;
      inflight <= rd_issue;
      if (accept) begin
        cur_addr <= cmd_addr_i;
        remain   <= cmd_len_i;
      end else if (wr_hs || rd_issue) begin
        cur_addr <= cur_addr + AW'(1);   // wraps silently
        remain   <= remain - LW'(1);
      end
      if (push) begin
        fifo_mem[fifo_wp] <= rdata_a_i;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (!push && pop) fifo_count <= fifo_count - 2'd1;
    end
  end

endmodule
